aht_sensor_seq: RTL and testbench
=================================

Name: aht_sensor_seq

Overview:
- Parametrised successor to the current AHT10 I2C command sequencer.
- Sits between the top-level/display logic and the existing byte-level I2C interface (req/cmd/data/done/rd_data handshake).
- Adds configurable timing, single-shot and periodic modes, busy-bit polling instead of a blind wait, init retry, per-byte timeout and error reporting.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; all ms delays are converted as CLK_HZ/1000*ms cycles
PWRUP_MS, 40, power-up wait before first init
MEAS_MS, 80, minimum wait after trigger before first status poll
POLL_MS, 10, gap between successive busy polls
PERIOD_MS, 500, idle interval between measurements in periodic mode
MAX_POLL, 8, busy polls allowed before error
INIT_RETRY, 3, init+check attempts before error
TIMEOUT_CYC, 1_000_000, maximum cycles req may stay high without done
I2C_ADR, 7'h38, sensor 7-bit address

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  level: 1 = periodic measurement every PERIOD_MS
trig  in  1  pulse: request one measurement (ignored unless in IDLE)
req  out  1  byte request to I2C interface, held until done
cmd  out  4  `CMD_* bit-OR from param.v
data  out  8  byte to send (address/command/argument)
done  in  1  one-cycle pulse: current byte finished; rd_data valid in same cycle
rd_data  in  8  byte read by interface
hum_data  out  20  raw humidity
temp_data  out  20  raw temperature
dout_vld  out  1  one-cycle pulse: new hum/temp valid
busy  out  1  high in any state except IDLE and ERR
err  out  1  sticky error flag, cleared only by reset
err_code  out  2  0 none, 1 init failed, 2 busy-poll exhausted, 3 done timeout

Behaviour:
- Clock: single clock clk. Reset: asynchronous, active-low rst_n.
- Reset values: state PWRUP; req=0, cmd=0, data=0; hum_data=0, temp_data=0; dout_vld=0, err=0, err_code=0; all counters 0.
- req/cmd/data are combinational from state and byte counter, so the next byte is presented in the cycle after done. Byte counter increments on done. Last byte of a transaction: counter clears and the state advances.
- States:
  - PWRUP: count PWRUP_MS -> INIT.
  - INIT: 4 bytes: START|WRITE {ADR,0}; WRITE 0xE1; WRITE 0x08; WRITE|STOP 0x00 -> CHECK.
  - CHECK: 4 bytes: START|WRITE {ADR,0}; WRITE 0x71; START|WRITE {ADR,1}; READ|STOP.
    - On last done with rd_data[3]=1 -> IDLE.
    - Otherwise increment retry count. If retry count = INIT_RETRY -> ERR with code 1, else -> INIT.
  - IDLE: delay counter runs only while en=1 and reaches PERIOD_MS -> TRIG. trig=1 -> TRIG immediately.
    - Counter clears on leaving IDLE or when en=0.
    - If trig and expiry coincide, exactly one measurement is taken.
  - TRIG: 4 bytes: START|WRITE {ADR,0}; WRITE 0xAC; WRITE 0x33; WRITE|STOP 0x00 -> WAIT.
  - WAIT: count MEAS_MS -> POLL. Poll count cleared on entry.
  - POLL: 2 bytes: START|WRITE {ADR,1}; READ|STOP.
    - rd_data[7]=0 -> READ.
    - Else increment poll count. If poll count = MAX_POLL -> ERR with code 2, else -> GAP.
  - GAP: count POLL_MS -> POLL.
  - READ: START|WRITE {ADR,1}, then N read bytes, the last one READ|STOP. N=6, or 7 with CRC.
    - Read bytes shift into a 48-bit register; the CRC byte is not shifted in.
    - On the last done: hum_data=reg[39:20], temp_data=reg[19:0], dout_vld=1 in the next cycle -> IDLE.
  - ERR: req=0, terminal until reset.
- Timeout: a watchdog counts while req=1 and clears on done or when req=0. Reaching TIMEOUT_CYC -> ERR with code 3 from any transaction state.
- done outside a transaction state is ignored.
- First error code latched wins.
- rst_n low mid-transaction drops req asynchronously. The external interface is responsible for bus recovery.

Optional Feature:
- Macro AHT_CRC_EN.
- Defined:
  - READ fetches 7 data bytes; byte 7 is CRC-8 (poly 0x31, init 0xFF) over bytes 1..6.
  - On mismatch, outputs are not updated and no dout_vld is pulsed. A crc_err output pulses for one cycle and the state returns to IDLE (no sticky err).
- Undefined: 6 data bytes, no crc_err port.

Decomposition:
- `CMD_START/WRITE/READ/STOP and `I2C_ADR stay in param.v.
- Add to param.v: AHT_CMD_INIT 0xE1, AHT_CMD_STATUS 0x71, AHT_CMD_TRIG 0xAC, AHT_ARG0 0x33, AHT_ARG1 0x00, AHT_CRC_POLY 0x31, state encodings.
- Sub-module aht_crc8: byte-serial CRC with clear, enable and 8-bit data input; instantiated only under AHT_CRC_EN.

Test Plan:
Bench setup: CLK_HZ=1000, all ms params =2..5, behavioural I2C slave model answering done 4 cycles after req.
- Power-up, slave status 0x08: after PWRUP, sees 0x70,0xE1,0x08,0x00 then check read -> IDLE, busy=0.
- Status 0x00 on every check, INIT_RETRY=3 -> exactly 3 INIT sequences, then err=1, err_code=1, req stays 0.
- trig pulse, poll returns 0x80,0x80,0x1C, data bytes 1C 6E 5A 35 B2 C4 -> 3 polls; hum_data=0x6E5A3, temp_data=0x5B2C4, one dout_vld.
- en=1, no trig -> measurements start every PERIOD_MS. trig coinciding with expiry -> single TRIG sequence.
- Slave never returns done -> err_code=3 after TIMEOUT_CYC cycles with req high.
- AHT_CRC_EN, correct CRC -> dout_vld. Corrupted CRC -> crc_err pulse, hum/temp unchanged, back in IDLE.

Source files
------------

// File: rtl/aht_sensor_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | aht_sensor_seq_pkg: byte commands, AHT10 opcodes, states, CRC step fn.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package aht_sensor_seq_pkg;

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_READ  = 4'b0100;
  localparam logic [3:0] CMD_STOP  = 4'b1000;

  localparam logic [7:0] AHT_CMD_INIT   = 8'hE1;
  localparam logic [7:0] AHT_INIT_ARG   = 8'h08;
  localparam logic [7:0] AHT_CMD_STATUS = 8'h71;
  localparam logic [7:0] AHT_CMD_TRIG   = 8'hAC;
  localparam logic [7:0] AHT_ARG0       = 8'h33;
  localparam logic [7:0] AHT_ARG1       = 8'h00;
  localparam logic [7:0] AHT_CRC_POLY   = 8'h31;
  localparam logic [7:0] AHT_CRC_INIT   = 8'hFF;

  typedef enum logic [3:0] {
    ST_PWRUP = 4'd0,
    ST_INIT  = 4'd1,
    ST_CHECK = 4'd2,
    ST_IDLE  = 4'd3,
    ST_TRIG  = 4'd4,
    ST_WAIT  = 4'd5,
    ST_POLL  = 4'd6,
    ST_GAP   = 4'd7,
    ST_READ  = 4'd8,
    ST_ERR   = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_INIT    = 2'd1,
    ERR_POLL    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  // MSB-first CRC-8 update over one byte, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ AHT_CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aht_crc8.sv
// +--------------------------------------------------------------------------+
// | aht_crc8: byte-serial CRC-8 (poly 0x31, init 0xFF) with clear and enable.|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module aht_crc8
  import aht_sensor_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= AHT_CRC_INIT;
    end else if (clr_i) begin
      crc_q <= AHT_CRC_INIT;
    end else if (en_i) begin
      crc_q <= crc8_byte(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/aht_sensor_seq.sv
// +--------------------------------------------------------------------------+
// | aht_sensor_seq: AHT10 command sequencer over a byte-level I2C handshake; |
// | optional CRC check with macro AHT_CRC_EN.  Revision 1.0                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module aht_sensor_seq
  import aht_sensor_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned PWRUP_MS    = 40,
  parameter int unsigned MEAS_MS     = 80,
  parameter int unsigned POLL_MS     = 10,
  parameter int unsigned PERIOD_MS   = 500,
  parameter int unsigned MAX_POLL    = 8,
  parameter int unsigned INIT_RETRY  = 3,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter logic [6:0]  I2C_ADR     = 7'h38
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        trig,
  output logic        req,
  output logic [3:0]  cmd,
  output logic [7:0]  data,
  input  logic        done,
  input  logic [7:0]  rd_data,
  output logic [19:0] hum_data,
  output logic [19:0] temp_data,
  output logic        dout_vld,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
`ifdef AHT_CRC_EN
  ,
  output logic        crc_err
`endif
);

  localparam int unsigned MS_CYC     = CLK_HZ / 1000;
  localparam int unsigned PWRUP_CYC  = MS_CYC * PWRUP_MS;
  localparam int unsigned MEAS_CYC   = MS_CYC * MEAS_MS;
  localparam int unsigned POLL_CYC   = MS_CYC * POLL_MS;
  localparam int unsigned PERIOD_CYC = MS_CYC * PERIOD_MS;
`ifdef AHT_CRC_EN
  localparam int unsigned NRD = 7;
`else
  localparam int unsigned NRD = 6;
`endif
  localparam logic [7:0] ADR_W = {I2C_ADR, 1'b0};
  localparam logic [7:0] ADR_R = {I2C_ADR, 1'b1};

  state_e      state_q, state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [31:0] dly_q, dly_d;
  logic [31:0] wdt_q, wdt_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  poll_q, poll_d;
  logic [39:0] shreg_q, shreg_d;
  logic [19:0] hum_q, hum_d, temp_q, temp_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  err_e        code_q, code_d;
  logic        crc_err_q, crc_err_d;

  logic [2:0]  last_idx;
  logic        w_last, w_byte_in, w_err_set;
  logic [39:0] w_shift;
  err_e        w_err_new;

  // Byte presented to the interface is a pure function of state and byte index.
  always_comb begin
    req      = 1'b0;
    cmd      = '0;
    data     = '0;
    last_idx = 3'd3;
    case (state_q)
      ST_INIT: begin
        req = 1'b1;
        case (bcnt_q)
          3'd0:    begin cmd = CMD_START | CMD_WRITE; data = ADR_W;        end
          3'd1:    begin cmd = CMD_WRITE;             data = AHT_CMD_INIT; end
          3'd2:    begin cmd = CMD_WRITE;             data = AHT_INIT_ARG; end
          default: begin cmd = CMD_WRITE | CMD_STOP;  data = AHT_ARG1;     end
        endcase
      end
      ST_CHECK: begin
        req = 1'b1;
        case (bcnt_q)
          3'd0:    begin cmd = CMD_START | CMD_WRITE; data = ADR_W;          end
          3'd1:    begin cmd = CMD_WRITE;             data = AHT_CMD_STATUS; end
          3'd2:    begin cmd = CMD_START | CMD_WRITE; data = ADR_R;          end
          default: begin cmd = CMD_READ | CMD_STOP;                          end
        endcase
      end
      ST_TRIG: begin
        req = 1'b1;
        case (bcnt_q)
          3'd0:    begin cmd = CMD_START | CMD_WRITE; data = ADR_W;        end
          3'd1:    begin cmd = CMD_WRITE;             data = AHT_CMD_TRIG; end
          3'd2:    begin cmd = CMD_WRITE;             data = AHT_ARG0;     end
          default: begin cmd = CMD_WRITE | CMD_STOP;  data = AHT_ARG1;     end
        endcase
      end
      ST_POLL: begin
        req      = 1'b1;
        last_idx = 3'd1;
        if (bcnt_q == 3'd0) begin
          cmd  = CMD_START | CMD_WRITE;
          data = ADR_R;
        end else begin
          cmd = CMD_READ | CMD_STOP;
        end
      end
      ST_READ: begin
        req      = 1'b1;
        last_idx = 3'(NRD);
        if (bcnt_q == 3'd0) begin
          cmd  = CMD_START | CMD_WRITE;
          data = ADR_R;
        end else if (bcnt_q == 3'(NRD)) begin
          cmd = CMD_READ | CMD_STOP;
        end else begin
          cmd = CMD_READ;
        end
      end
      default: ;
    endcase
  end

  assign w_last    = req && done && (bcnt_q == last_idx);
  // Only the six data bytes feed the shifter and CRC; a trailing CRC byte does not.
  assign w_byte_in = (state_q == ST_READ) && req && done && (bcnt_q != 3'd0) && (bcnt_q <= 3'd6);
  assign w_shift   = {shreg_q[31:0], rd_data};

`ifdef AHT_CRC_EN
  logic [7:0] crc_val;

  aht_crc8 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q != ST_READ),
    .en_i   (w_byte_in),
    .data_i (rd_data),
    .crc_o  (crc_val)
  );
`endif

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    dly_d     = dly_q;
    wdt_d     = (req && !done) ? wdt_q + 32'd1 : '0;
    retry_d   = retry_q;
    poll_d    = poll_q;
    shreg_d   = w_byte_in ? w_shift : shreg_q;
    hum_d     = hum_q;
    temp_d    = temp_q;
    vld_d     = 1'b0;
    err_d     = err_q;
    code_d    = code_q;
    crc_err_d = 1'b0;
    w_err_set = 1'b0;
    w_err_new = ERR_NONE;

    if (req && done) bcnt_d = w_last ? 3'd0 : bcnt_q + 3'd1;

    case (state_q)
      ST_PWRUP: begin
        if (dly_q + 32'd1 >= 32'(PWRUP_CYC)) begin
          state_d = ST_INIT;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + 32'd1;
        end
      end
      ST_INIT: if (w_last) state_d = ST_CHECK;
      ST_CHECK: begin
        if (w_last) begin
          if (rd_data[3]) begin
            state_d = ST_IDLE;
          end else begin
            retry_d = retry_q + 8'd1;
            if (retry_q + 8'd1 == 8'(INIT_RETRY)) begin
              state_d   = ST_ERR;
              w_err_set = 1'b1;
              w_err_new = ERR_INIT;
            end else begin
              state_d = ST_INIT;
            end
          end
        end
      end
      ST_IDLE: begin
        // A trig landing on the period expiry still yields a single TRIG entry.
        if (trig) begin
          state_d = ST_TRIG;
          dly_d   = '0;
        end else if (en) begin
          if (dly_q + 32'd1 >= 32'(PERIOD_CYC)) begin
            state_d = ST_TRIG;
            dly_d   = '0;
          end else begin
            dly_d = dly_q + 32'd1;
          end
        end else begin
          dly_d = '0;
        end
      end
      ST_TRIG: begin
        if (w_last) begin
          state_d = ST_WAIT;
          poll_d  = '0;
        end
      end
      ST_WAIT, ST_GAP: begin
        if (dly_q + 32'd1 >= 32'((state_q == ST_WAIT) ? MEAS_CYC : POLL_CYC)) begin
          state_d = ST_POLL;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + 32'd1;
        end
      end
      ST_POLL: begin
        if (w_last) begin
          if (!rd_data[7]) begin
            state_d = ST_READ;
          end else begin
            poll_d = poll_q + 8'd1;
            if (poll_q + 8'd1 == 8'(MAX_POLL)) begin
              state_d   = ST_ERR;
              w_err_set = 1'b1;
              w_err_new = ERR_POLL;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_READ: begin
        if (w_last) begin
          state_d = ST_IDLE;
`ifdef AHT_CRC_EN
          if (rd_data == crc_val) begin
            hum_d  = shreg_q[39:20];
            temp_d = shreg_q[19:0];
            vld_d  = 1'b1;
          end else begin
            crc_err_d = 1'b1;
          end
`else
          hum_d  = w_shift[39:20];
          temp_d = w_shift[19:0];
          vld_d  = 1'b1;
`endif
        end
      end
      default: ;
    endcase

    if (req && !done && (wdt_q + 32'd1 >= 32'(TIMEOUT_CYC))) begin
      state_d   = ST_ERR;
      bcnt_d    = '0;
      w_err_set = 1'b1;
      w_err_new = ERR_TIMEOUT;
    end

    if (w_err_set && !err_q) begin
      err_d  = 1'b1;
      code_d = w_err_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PWRUP;
      bcnt_q    <= '0;
      dly_q     <= '0;
      wdt_q     <= '0;
      retry_q   <= '0;
      poll_q    <= '0;
      shreg_q   <= '0;
      hum_q     <= '0;
      temp_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      crc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      dly_q     <= dly_d;
      wdt_q     <= wdt_d;
      retry_q   <= retry_d;
      poll_q    <= poll_d;
      shreg_q   <= shreg_d;
      hum_q     <= hum_d;
      temp_q    <= temp_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      code_q    <= code_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign hum_data  = hum_q;
  assign temp_data = temp_q;
  assign dout_vld  = vld_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign err       = err_q;
  assign err_code  = code_q;
`ifdef AHT_CRC_EN
  assign crc_err   = crc_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aht_sensor_seq.sv
// +--------------------------------------------------------------------------+
// | tb_aht_sensor_seq: byte/measurement scoreboard bench for aht_sensor_seq. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_aht_sensor_seq;

  localparam int unsigned TO_CYC = 50;
  localparam int unsigned PER    = 5;
`ifdef AHT_CRC_EN
  localparam int NRD = 7;
`else
  localparam int NRD = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        trig = 1'b0;
  logic        done = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        req;
  logic [3:0]  cmd;
  logic [7:0]  data;
  logic [19:0] hum_data, temp_data;
  logic        dout_vld, busy, err;
  logic [1:0]  err_code;
`ifdef AHT_CRC_EN
  logic        crc_err;
`endif

  always #5 clk = ~clk;

  aht_sensor_seq #(
    .CLK_HZ(1000), .PWRUP_MS(3), .MEAS_MS(4), .POLL_MS(2), .PERIOD_MS(PER),
    .MAX_POLL(3), .INIT_RETRY(3), .TIMEOUT_CYC(TO_CYC), .I2C_ADR(7'h38)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trig(trig),
    .req(req), .cmd(cmd), .data(data), .done(done), .rd_data(rd_data),
    .hum_data(hum_data), .temp_data(temp_data), .dout_vld(dout_vld),
    .busy(busy), .err(err), .err_code(err_code)
`ifdef AHT_CRC_EN
    , .crc_err(crc_err)
`endif
  );

  typedef struct packed { logic [3:0] c; logic [7:0] d; } byte_t;
  byte_t       exp_b[$];
  logic [39:0] exp_m[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  def_st = 8'h08;
  logic        mute = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_crc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] crc8(input logic [47:0] b);
    logic [7:0] c = 8'hFF;
    for (int i = 5; i >= 0; i--) begin
      c = c ^ b[i*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  task automatic push_b(input logic [3:0] c, input logic [7:0] d);
    byte_t e;
    e.c = c; e.d = d;
    exp_b.push_back(e);
  endtask
  task automatic push_init();
    push_b(4'h3, 8'h70); push_b(4'h2, 8'hE1); push_b(4'h2, 8'h08); push_b(4'hA, 8'h00);
  endtask
  task automatic push_check();
    push_b(4'h3, 8'h70); push_b(4'h2, 8'h71); push_b(4'h3, 8'h71); push_b(4'hC, 8'h00);
  endtask
  task automatic push_trig();
    push_b(4'h3, 8'h70); push_b(4'h2, 8'hAC); push_b(4'h2, 8'h33); push_b(4'hA, 8'h00);
  endtask
  task automatic push_poll();
    push_b(4'h3, 8'h71); push_b(4'hC, 8'h00);
  endtask
  task automatic push_read();
    push_b(4'h3, 8'h71);
    for (int i = 0; i < NRD - 1; i++) push_b(4'h4, 8'h00);
    push_b(4'hC, 8'h00);
  endtask
  // Six sensor bytes in bus order; a CRC byte follows when checking is built in.
  task automatic push_data(input logic [47:0] b, input logic [7:0] crc_flip);
    for (int i = 5; i >= 0; i--) rd_q.push_back(b[i*8 +: 8]);
    if (NRD == 7) rd_q.push_back(crc8(b) ^ crc_flip);
  endtask

  // Behavioural I2C slave: logs and scores each byte, answers done 4 cycles later.
  initial begin
    byte_t      e;
    logic [7:0] ans;
    forever begin
      @(negedge clk);
      if (req && !mute) begin
        if (exp_b.size() == 0) begin
          n_chk++;
          $display("FAIL i2c_byte_extra: got cmd 0x%0h data 0x%0h, required no byte", cmd, data);
        end else begin
          e = exp_b.pop_front();
          check("i2c_byte", {cmd, data}, {e.c, e.d});
        end
        if ((cmd & 4'h4) != 4'h0) ans = (rd_q.size() != 0) ? rd_q.pop_front() : def_st;
        else ans = 8'h00;
        repeat (3) @(negedge clk);
        rd_data = ans;
        done    = 1'b1;
        @(negedge clk);
        done    = 1'b0;
        rd_data = 8'h00;
      end
    end
  end

  // Measurement monitor: every dout_vld pops one expected {hum,temp}.
  initial begin
    forever begin
      @(negedge clk);
      if (dout_vld) begin
        if (exp_m.size() == 0) begin
          n_chk++;
          $display("FAIL meas_extra: got hum 0x%0h temp 0x%0h, required no dout_vld", hum_data, temp_data);
        end else begin
          check("meas", {hum_data, temp_data}, exp_m.pop_front());
        end
      end
`ifdef AHT_CRC_EN
      if (crc_err) n_crc++;
`endif
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_not_busy(input string name, input int max);
    int i = 0;
    while (busy && i < max) begin @(negedge clk); i++; end
    check(name, busy, 1'b0);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check({name, "_bytes_left"}, exp_b.size(), 0);
    check({name, "_meas_left"}, exp_m.size(), 0);
  endtask

  initial begin
    int seen, k, hi;

    // Init failure: status never shows the calibrated bit.
    def_st = 8'h00;
    @(negedge clk);
    check("rst_req", req, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_err", {err, err_code}, 3'b000);
    check("rst_out", {hum_data, temp_data, dout_vld}, 41'd0);
    repeat (3) begin push_init(); push_check(); end
    do_reset();
    wait_not_busy("init_fail_done", 600);
    check("init_fail_err", {err, err_code}, 3'b101);
    repeat (20) @(negedge clk);
    check("init_fail_req", req, 1'b0);
    check_drained("init_fail");

    // Clean power-up.
    def_st = 8'h08;
    push_init(); push_check();
    do_reset();
    @(negedge clk);
    wait_not_busy("pwrup_idle", 400);
    check("pwrup_err", {err, err_code}, 3'b000);
    check_drained("pwrup");

    // Single shot with two busy polls.
    rd_q.push_back(8'h80); rd_q.push_back(8'h80); rd_q.push_back(8'h1C);
    push_data(48'h1C6E5A35B2C4, 8'h00);
    push_trig(); push_poll(); push_poll(); push_poll(); push_read();
    exp_m.push_back({20'h6E5A3, 20'h5B2C4});
    pulse_trig();
    wait_not_busy("single_done", 400);
    repeat (3) @(negedge clk);
    check_drained("single");

`ifdef AHT_CRC_EN
    // Corrupted CRC byte: no update, one crc_err pulse.
    rd_q.push_back(8'h1C);
    push_data(48'h1C1122334455, 8'h01);
    push_trig(); push_poll(); push_read();
    pulse_trig();
    wait_not_busy("crc_bad_done", 400);
    repeat (3) @(negedge clk);
    check("crc_err_pulses", n_crc, 1);
    check("crc_hold", {hum_data, temp_data}, {20'h6E5A3, 20'h5B2C4});
    check_drained("crc_bad");
`endif

    // Periodic mode; the third start coincides with a trig pulse.
    rd_q.push_back(8'h1C); push_data(48'h1C123456789A, 8'h00);
    rd_q.push_back(8'h1C); push_data(48'h1CABCDEF0123, 8'h00);
    rd_q.push_back(8'h1C); push_data(48'h1CFFFFFFFFFF, 8'h00);
    repeat (3) begin push_trig(); push_poll(); push_read(); end
    exp_m.push_back({20'h12345, 20'h6789A});
    exp_m.push_back({20'hABCDE, 20'hF0123});
    exp_m.push_back({20'hFFFFF, 20'hFFFFF});
    en   = 1'b1;
    seen = 0;
    k    = 0;
    while (seen < 2 && k < 2000) begin @(negedge clk); k++; if (dout_vld) seen++; end
    check("periodic_two", seen, 2);
    repeat (PER - 1) @(negedge clk);
    pulse_trig();
    k = 0;
    while (!dout_vld && k < 2000) begin @(negedge clk); k++; end
    check("periodic_third", dout_vld, 1'b1);
    en = 1'b0;
    repeat (3 * PER) @(negedge clk);
    check("periodic_stop_busy", busy, 1'b0);
    check_drained("periodic");

    // Busy bit never clears: poll budget exhausted.
    rd_q.push_back(8'h80); rd_q.push_back(8'h80); rd_q.push_back(8'h80);
    push_trig(); push_poll(); push_poll(); push_poll();
    pulse_trig();
    wait_not_busy("poll_exh_done", 400);
    check("poll_exh_err", {err, err_code}, 3'b110);
    check_drained("poll_exh");

    // Slave never answers: watchdog.
    push_init(); push_check();
    do_reset();
    @(negedge clk);
    wait_not_busy("to_pwrup", 400);
    mute = 1'b1;
    pulse_trig();
    hi = req ? 1 : 0;
    k  = 0;
    while (!err && k < int'(TO_CYC) + 40) begin @(negedge clk); if (req) hi++; k++; end
    check("to_err", {err, err_code}, 3'b111);
    check("to_req_cycles", hi, TO_CYC);
    check("to_req_low", req, 1'b0);
    check_drained("timeout");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
